// File: rtl/rv_pkg.sv
// Shared integer-register-file definitions for the writeback path.
package rv_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [XLEN-1:0]       xdata_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_X0 = '0;

    typedef struct packed {
        reg_addr_t rd;
        xdata_t    data;
    } wb_req_t;

    function automatic logic is_x0(input reg_addr_t a);
        return a == REG_X0;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback, MUL/DIV result, issue and register-file write signals of rf_wb_arbiter.
interface rf_wb_arbiter_if;
    import rv_pkg::*;

    logic      alu_wb_valid;
    reg_addr_t alu_wb_rd;
    xdata_t    alu_wb_data;

    logic      md_valid;
    reg_addr_t md_rd;
    xdata_t    md_data;
    logic      md_ready;

    logic      issue_valid;
    logic      issue_is_md;
    reg_addr_t issue_rs1;
    reg_addr_t issue_rs2;
    reg_addr_t issue_rd;
    logic      issue_stall;

    logic      rf_wr_en;
    reg_addr_t rf_rd;
    xdata_t    rf_wr_data;

    modport slave (
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  md_valid, md_rd, md_data,
        output md_ready,
        input  issue_valid, issue_is_md, issue_rs1, issue_rs2, issue_rd,
        output issue_stall,
        output rf_wr_en, rf_rd, rf_wr_data
    );

    modport master (
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output md_valid, md_rd, md_data,
        input  md_ready,
        output issue_valid, issue_is_md, issue_rs1, issue_rs2, issue_rd,
        input  issue_stall,
        input  rf_wr_en, rf_rd, rf_wr_data
    );

endinterface

// File: rtl/rf_wb_arbiter_md_scoreboard.sv
// Tracks destinations of outstanding MUL/DIV ops and decides issue stalls.
module md_scoreboard
    import rv_pkg::*;
#(
    parameter int unsigned MAX_MD_OUT = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      issue_valid_i,
    input  logic      issue_is_md_i,
    input  reg_addr_t issue_rs1_i,
    input  reg_addr_t issue_rs2_i,
    input  reg_addr_t issue_rd_i,
    input  logic      force_bubble_i,
    input  logic      drain_i,
    input  reg_addr_t drain_rd_i,
    output logic      issue_stall_o
);

    localparam int unsigned CW = $clog2(MAX_MD_OUT + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CW-1:0]       md_cnt_q, md_cnt_d;
    logic                at_cap;
    logic                hazard;
    logic                md_fire;

    assign at_cap  = (md_cnt_q == CW'(MAX_MD_OUT));
    assign md_fire = issue_valid_i && !issue_stall_o && issue_is_md_i;

    always_comb begin
        hazard = pending_q[issue_rs1_i] || pending_q[issue_rs2_i] || pending_q[issue_rd_i];
        issue_stall_o = issue_valid_i &&
                        (hazard || (issue_is_md_i && at_cap) || force_bubble_i);
    end

    // WAW stall on issue_rd guarantees set and clear never target the same bit.
    always_comb begin
        pending_d = pending_q;
        if (drain_i) begin
            pending_d[drain_rd_i] = 1'b0;
        end
        if (md_fire && !is_x0(issue_rd_i)) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[REG_X0] = 1'b0;
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        unique case ({md_fire, drain_i})
            2'b10:   if (!at_cap) md_cnt_d = md_cnt_q + CW'(1);
            2'b01:   if (md_cnt_q != '0) md_cnt_d = md_cnt_q - CW'(1);
            default: md_cnt_d = md_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            md_cnt_q  <= '0;
        end else begin
            pending_q <= pending_d;
            md_cnt_q  <= md_cnt_d;
        end
    end

    a_no_drain_underflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(drain_i && (md_cnt_q == '0))
    );

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: ALU writeback first, buffered MUL/DIV result otherwise.
module rf_wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned MAX_MD_OUT   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             rst_n,
    rf_wb_arbiter_if.slave  bus
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic          buf_valid_q, buf_valid_d;
    wb_req_t       buf_q, buf_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    logic alu_own;
    logic drain;
    logic capture;
    logic force_bubble;

    assign alu_own      = bus.alu_wb_valid && !is_x0(bus.alu_wb_rd);
    assign drain        = buf_valid_q && !alu_own;
    assign capture      = bus.md_valid && !buf_valid_q;
    assign force_bubble = (starve_cnt_q >= SW'(STARVE_LIMIT));
    assign bus.md_ready = !buf_valid_q;

    // Port zeroed unless a real write happens; x0 writes never assert wr_en.
    always_comb begin
        bus.rf_wr_en   = 1'b0;
        bus.rf_rd      = '0;
        bus.rf_wr_data = '0;
        if (alu_own) begin
            bus.rf_wr_en   = 1'b1;
            bus.rf_rd      = bus.alu_wb_rd;
            bus.rf_wr_data = bus.alu_wb_data;
        end else if (drain && !is_x0(buf_q.rd)) begin
            bus.rf_wr_en   = 1'b1;
            bus.rf_rd      = buf_q.rd;
            bus.rf_wr_data = buf_q.data;
        end
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (capture) begin
            buf_valid_d = 1'b1;
            buf_d.rd    = bus.md_rd;
            buf_d.data  = bus.md_data;
        end else if (drain) begin
            buf_valid_d = 1'b0;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (drain) begin
            starve_cnt_d = '0;
        end else if (buf_valid_q && alu_own && !force_bubble) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q  <= 1'b0;
            buf_q        <= '0;
            starve_cnt_q <= '0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_q        <= buf_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    md_scoreboard #(
        .MAX_MD_OUT (MAX_MD_OUT)
    ) u_sb (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid_i  (bus.issue_valid),
        .issue_is_md_i  (bus.issue_is_md),
        .issue_rs1_i    (bus.issue_rs1),
        .issue_rs2_i    (bus.issue_rs2),
        .issue_rd_i     (bus.issue_rd),
        .force_bubble_i (force_bubble),
        .drain_i        (drain),
        .drain_rd_i     (buf_q.rd),
        .issue_stall_o  (bus.issue_stall)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-computed per-cycle expectations.
module tb_rf_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if bus();

    rf_wb_arbiter #(
        .MAX_MD_OUT   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int unsigned en, input int unsigned rd,
                              input logic [63:0] data, input int unsigned rdy,
                              input int unsigned stall);
        chk({tag, ".wr_en"},   64'(bus.rf_wr_en),    64'(en));
        chk({tag, ".rf_rd"},   64'(bus.rf_rd),       64'(rd));
        chk({tag, ".wr_data"}, bus.rf_wr_data,       data);
        chk({tag, ".ready"},   64'(bus.md_ready),    64'(rdy));
        chk({tag, ".stall"},   64'(bus.issue_stall), 64'(stall));
    endtask

    task automatic drive(input int unsigned av, input int unsigned ard, input logic [63:0] ad,
                         input int unsigned mv, input int unsigned mrd, input logic [63:0] md,
                         input int unsigned iv, input int unsigned imd, input int unsigned rs1,
                         input int unsigned rs2, input int unsigned rd);
        bus.alu_wb_valid = 1'(av);
        bus.alu_wb_rd    = 5'(ard);
        bus.alu_wb_data  = ad;
        bus.md_valid     = 1'(mv);
        bus.md_rd        = 5'(mrd);
        bus.md_data      = md;
        bus.issue_valid  = 1'(iv);
        bus.issue_is_md  = 1'(imd);
        bus.issue_rs1    = 5'(rs1);
        bus.issue_rs2    = 5'(rs2);
        bus.issue_rd     = 5'(rd);
    endtask

    // Drive at posedge+1, check at posedge+5, advance to next posedge+1.
    task automatic cyc(input string tag,
                       input int unsigned av, input int unsigned ard, input logic [63:0] ad,
                       input int unsigned mv, input int unsigned mrd, input logic [63:0] md,
                       input int unsigned iv, input int unsigned imd, input int unsigned rs1,
                       input int unsigned rs2, input int unsigned rd,
                       input int unsigned e_en, input int unsigned e_rd, input logic [63:0] e_data,
                       input int unsigned e_rdy, input int unsigned e_stall);
        drive(av, ard, ad, mv, mrd, md, iv, imd, rs1, rs2, rd);
        #4;
        expect_out(tag, e_en, e_rd, e_data, e_rdy, e_stall);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 5, 5, 5);
        @(posedge clk);
        #1;
        #4;
        expect_out("reset", 0, 0, 64'h0, 1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic MUL/DIV path
        cyc("mul5",    0,0,64'h0,  0,0,64'h0,   1,1,1,2,5,  0,0,64'h0,  1,0);
        cyc("add_raw", 0,0,64'h0,  1,5,64'h2A,  1,0,5,0,6,  0,0,64'h0,  1,1);
        cyc("drain5",  0,0,64'h0,  0,0,64'h0,   1,0,5,0,6,  1,5,64'h2A, 0,1);
        cyc("add_go",  0,0,64'h0,  0,0,64'h0,   1,0,5,0,6,  0,0,64'h0,  1,0);

        // Contention and forced bubble
        cyc("mul7",    0,0,64'h0,  0,0,64'h0,   1,1,1,2,7,  0,0,64'h0,  1,0);
        cyc("cap7",    1,3,64'h33, 1,7,64'h77,  0,0,0,0,0,  1,3,64'h33, 1,0);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("starve%0d", i),
                       1,3,64'h33, 0,0,64'h0,   1,0,1,2,4,  1,3,64'h33, 0,0);
        end
        cyc("bubble",  1,3,64'h33, 0,0,64'h0,   1,0,1,2,4,  1,3,64'h33, 0,1);
        cyc("drain7",  0,0,64'h0,  0,0,64'h0,   1,0,1,2,4,  1,7,64'h77, 0,1);
        cyc("bub_off", 0,0,64'h0,  0,0,64'h0,   1,0,1,2,4,  0,0,64'h0,  1,0);

        // x0 masking
        cyc("mul8",    0,0,64'h0,  0,0,64'h0,   1,1,1,2,8,  0,0,64'h0,  1,0);
        cyc("alu_x0",  1,0,64'hFF, 1,8,64'h88,  0,0,0,0,0,  0,0,64'h0,  1,0);
        cyc("x0_drn",  1,0,64'hFF, 0,0,64'h0,   0,0,0,0,0,  1,8,64'h88, 0,0);
        cyc("mul0",    0,0,64'h0,  0,0,64'h0,   1,1,1,2,0,  0,0,64'h0,  1,0);
        cyc("x0_free", 0,0,64'h0,  1,0,64'h99,  1,0,0,0,0,  0,0,64'h0,  1,0);
        cyc("drn_x0",  0,0,64'h0,  0,0,64'h0,   0,0,0,0,0,  0,0,64'h0,  0,0);
        cyc("idle",    0,0,64'h0,  0,0,64'h0,   0,0,0,0,0,  0,0,64'h0,  1,0);

        // Capacity
        cyc("mul10",   0,0,64'h0,  0,0,64'h0,   1,1,1,2,10, 0,0,64'h0,  1,0);
        cyc("mul11",   0,0,64'h0,  0,0,64'h0,   1,1,1,2,11, 0,0,64'h0,  1,0);
        cyc("mul_cap", 0,0,64'h0,  0,0,64'h0,   1,1,1,2,12, 0,0,64'h0,  1,1);
        cyc("add_cap", 0,0,64'h0,  0,0,64'h0,   1,0,1,2,13, 0,0,64'h0,  1,0);
        cyc("cap10",   0,0,64'h0,  1,10,64'hA0, 0,0,0,0,0,  0,0,64'h0,  1,0);
        cyc("drain10", 0,0,64'h0,  0,0,64'h0,   0,0,0,0,0,  1,10,64'hA0,0,0);
        cyc("cap11",   0,0,64'h0,  1,11,64'hB1, 0,0,0,0,0,  0,0,64'h0,  1,0);
        cyc("drn_mul", 0,0,64'h0,  0,0,64'h0,   1,1,1,2,12, 1,11,64'hB1,0,0);
        cyc("mul14",   0,0,64'h0,  0,0,64'h0,   1,1,1,2,14, 0,0,64'h0,  1,0);
        cyc("mul_cp2", 0,0,64'h0,  0,0,64'h0,   1,1,1,2,15, 0,0,64'h0,  1,1);
        cyc("cap12",   0,0,64'h0,  1,12,64'hC2, 0,0,0,0,0,  0,0,64'h0,  1,0);
        cyc("drain12", 0,0,64'h0,  0,0,64'h0,   0,0,0,0,0,  1,12,64'hC2,0,0);
        cyc("cap14",   0,0,64'h0,  1,14,64'hE4, 0,0,0,0,0,  0,0,64'h0,  1,0);
        cyc("drain14", 0,0,64'h0,  0,0,64'h0,   0,0,0,0,0,  1,14,64'hE4,0,0);

        // WAW
        cyc("mul9",    0,0,64'h0,  0,0,64'h0,   1,1,1,2,9,  0,0,64'h0,  1,0);
        cyc("waw9",    0,0,64'h0,  0,0,64'h0,   1,0,1,2,9,  0,0,64'h0,  1,1);
        cyc("cap9",    0,0,64'h0,  1,9,64'h99,  1,0,1,2,9,  0,0,64'h0,  1,1);
        cyc("drain9",  0,0,64'h0,  0,0,64'h0,   1,0,1,2,9,  1,9,64'h99, 0,1);
        cyc("waw_go",  0,0,64'h0,  0,0,64'h0,   1,0,1,2,9,  0,0,64'h0,  1,0);

        // Reset with a buffered result and pending[5]
        cyc("mul5b",   0,0,64'h0,  0,0,64'h0,   1,1,1,2,5,  0,0,64'h0,  1,0);
        cyc("cap5b",   1,3,64'h33, 1,5,64'h55,  0,0,0,0,0,  1,3,64'h33, 1,0);
        drive(1, 3, 64'h33, 0, 0, 64'h0, 1, 0, 5, 0, 6);
        #4;
        expect_out("pre_rst", 1, 3, 64'h33, 0, 1);
        #1;
        rst_n = 1'b0;
        bus.alu_wb_valid = 1'b0;
        #1;
        expect_out("mid_rst", 0, 0, 64'h0, 1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("post_rst",0,0,64'h0,  0,0,64'h0,   1,0,5,0,6,  0,0,64'h0,  1,0);
        cyc("mul20",   0,0,64'h0,  0,0,64'h0,   1,1,1,2,20, 0,0,64'h0,  1,0);
        cyc("mul21",   0,0,64'h0,  0,0,64'h0,   1,1,1,2,21, 0,0,64'h0,  1,0);
        cyc("mul22",   0,0,64'h0,  0,0,64'h0,   1,1,1,2,22, 0,0,64'h0,  1,1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
